// File: rtl/regfile_dump.sv
// Streams a sync header followed by registers x00..x(N_REGS-1), LSB-first, over a
// valid/ready byte channel by walking one read port of the register file.
module regfile_dump #(
  parameter int          N_REGS = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [4:0] LAST_ADDR = 5'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] snap_q, snap_d;
  logic [1:0]  idx_q, idx_d;
  logic        hs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rd_addr_q <= 5'd0;
      snap_q    <= 32'd0;
      idx_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
    end
  end

  // tx_valid and tx_data are pure functions of registered state, so they hold
  // steady under backpressure and never depend on tx_ready.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b1;
    done      = 1'b0;
    hs        = tx_ready;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d   = S_HDR;
          rd_addr_d = 5'd0;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (hs) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d  = rd_data;
        idx_d   = 2'd0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = snap_q[{idx_q, 3'b000} +: 8];
        if (hs) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else if (rd_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            rd_addr_d = rd_addr_q + 5'd1;
            state_d   = S_LOAD;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: two instances (default and N_REGS=4/HEADER=5A)
// share one behavioural register file; expected streams come from that array.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        tx_ready_a, tx_ready_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic        tx_valid_a, tx_valid_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;

  logic [31:0] regs [32];
  logic [7:0]  got  [$];
  logic [7:0]  expq [$];
  int checks   = 0;
  int failures = 0;
  int cyc;

  always #5 clk = ~clk;

  assign rd_data_a = (rd_addr_a == 5'd0) ? 32'd0 : regs[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? 32'd0 : regs[rd_addr_b];

  regfile_dump dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a)
  );

  regfile_dump #(.N_REGS(4), .HEADER(8'h5A)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int n, input logic [7:0] hdr);
    logic [31:0] w;
    expq.delete();
    expq.push_back(hdr);
    for (int r = 0; r < n; r++) begin
      w = (r == 0) ? 32'd0 : regs[r];
      for (int b = 0; b < 4; b++) expq.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_len"}, got.size(), expq.size());
    n = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", tag, i), got[i], expq[i]);
  endtask

  // Pulses start, collects accepted bytes and returns the cycle count from the
  // start edge to the done cycle inclusive (-1 on timeout). With events set,
  // re-pulses start and writes x20 once x10's first byte has been accepted.
  task automatic run_dump(input bit sel, input int ready_pct, input bit events, output int c_done);
    logic       v, dn, rdy, prev_v, prev_rdy, fired;
    logic [7:0] d, prev_d;
    got.delete();
    c_done = -1;
    prev_v = 1'b0; prev_rdy = 1'b0; prev_d = 8'h00; fired = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      start_a = 1'b0;
      v  = sel ? tx_valid_b : tx_valid_a;
      d  = sel ? tx_data_b  : tx_data_a;
      dn = sel ? done_b     : done_a;
      if (prev_v && !prev_rdy) begin
        chk("hold_valid", v, 1'b1);
        chk("hold_data", d, prev_d);
      end
      if (dn) begin
        c_done = c;
        break;
      end
      rdy = ($urandom_range(99) < ready_pct);
      if (sel) tx_ready_b = rdy; else tx_ready_a = rdy;
      if (v && rdy) got.push_back(d);
      if (events && !fired && got.size() == 42) begin
        fired     = 1'b1;
        start_a   = 1'b1;
        regs[20]  = 32'hCAFEF00D;
      end
      prev_v = v; prev_rdy = rdy; prev_d = d;
      step();
    end
    start_a = 1'b0;
    if (c_done < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit hit;
    rst = 1'b0; start_a = 1'b1; start_b = 1'b1;
    tx_ready_a = 1'b1; tx_ready_b = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1]  = 32'hDEADBEEF;
    regs[31] = 32'h12345678;

    // Reset held with start high: nothing leaves IDLE.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_valid", tx_valid_a, 1'b0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_data", tx_data_a, 8'h00);
      chk("rst_addr", rd_addr_a, 5'd0);
      chk("rst_valid_b", tx_valid_b, 1'b0);
    end
    rst = 1'b1;
    start_b = 1'b0;
    step();
    chk("first_valid", tx_valid_a, 1'b1);
    chk("first_hdr", tx_data_a, 8'hA5);
    chk("first_busy", busy_a, 1'b1);
    start_a = 1'b0;
    rst = 1'b0;
    step();
    chk("rerst_valid", tx_valid_a, 1'b0);
    rst = 1'b1;
    step();

    // Full dump, always ready.
    build_exp(32, 8'hA5);
    run_dump(1'b0, 100, 1'b0, cyc);
    compare_stream("full");
    chk("full_cycles", cyc, 162);
    if (got.size() == 129) begin
      chk("x01_b0", got[5], 8'hEF);
      chk("x01_b3", got[8], 8'hDE);
      chk("x31_b0", got[125], 8'h78);
      chk("x31_b3", got[128], 8'h12);
    end
    step();
    chk("full_busy_fall", busy_a, 1'b0);
    chk("full_done_fall", done_a, 1'b0);

    // Backpressure at ~30% ready.
    run_dump(1'b0, 30, 1'b0, cyc);
    compare_stream("bp");
    step();
    chk("bp_busy_fall", busy_a, 1'b0);

    // Ignored start plus a write to x20 while x10 is being sent.
    regs[20] = 32'h0;
    run_dump(1'b0, 100, 1'b1, cyc);
    build_exp(32, 8'hA5);
    compare_stream("wr");
    chk("wr_cycles", cyc, 162);
    if (got.size() == 129) begin
      chk("x20_b0", got[81], 8'h0D);
      chk("x20_b1", got[82], 8'hF0);
      chk("x20_b2", got[83], 8'hFE);
      chk("x20_b3", got[84], 8'hCA);
    end
    step();
    chk("wr_no_restart", busy_a, 1'b0);

    // Reset during idx=2 of x05, then a clean restart.
    tx_ready_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    got.delete();
    hit = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (tx_valid_a && got.size() == 23) begin
        hit = 1'b1;
        break;
      end
      if (tx_valid_a) got.push_back(tx_data_a);
      step();
    end
    chk("mid_reached", hit, 1'b1);
    chk("mid_addr_before", rd_addr_a, 5'd5);
    rst = 1'b0;
    step();
    chk("mid_valid", tx_valid_a, 1'b0);
    chk("mid_busy", busy_a, 1'b0);
    chk("mid_addr", rd_addr_a, 5'd0);
    rst = 1'b1;
    step();
    run_dump(1'b0, 100, 1'b0, cyc);
    compare_stream("restart");
    chk("restart_cycles", cyc, 162);

    // N_REGS=4, HEADER=5A instance.
    build_exp(4, 8'h5A);
    run_dump(1'b1, 100, 1'b0, cyc);
    compare_stream("small");
    chk("small_cycles", cyc, 22);
    if (got.size() == 17) begin
      chk("small_hdr", got[0], 8'h5A);
      chk("small_x01_b0", got[5], 8'hEF);
    end
    step();
    chk("small_busy_fall", busy_b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug read-out engine that sits on one read channel of the 32×32 RISC-V register file and streams its contents out as bytes. On a `start` pulse it walks read addresses x00 upward, snapshots each 32-bit value, and emits a sync header followed by each register LSB-first over a valid/ready byte stream. The byte stream feeds the board's serial or debug transmitter. It is the reader-side counterpart of the register file's write channel and shares no state with the core's datapath.

## Interface
- `N_REGS`, default 32: number of registers dumped, x00..x(N_REGS-1); legal range 1..32.
- `HEADER`, default 8'hA5: sync byte sent before the first register.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  request a dump; honoured only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `rd_addr`  out  5  drives the register file's read address.
- `rd_data`  in  32  combinational read data from the register file for `rd_addr`.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  downstream accepts the byte this cycle.

## Operation
- States: IDLE, HDR, LOAD, SEND, DONE.
- IDLE: outputs at reset values. `start`=1 → HDR, `rd_addr`←0.
- HDR: `tx_valid`=1, `tx_data`=HEADER. On handshake (`tx_valid`&`tx_ready`) → LOAD.
- LOAD: `tx_valid`=0. Capture `rd_data` into the 32-bit snapshot register. Set byte index to 0 → SEND.
- SEND: `tx_valid`=1, `tx_data`=snapshot[8*idx +: 8], with idx 0..3 (LSB first).
  - Handshake with idx<3: idx++.
  - Handshake with idx==3 and `rd_addr`==N_REGS-1: → DONE.
  - Handshake with idx==3 otherwise: `rd_addr`++ → LOAD.
- DONE: `done`=1 for exactly one cycle, `tx_valid`=0 → IDLE. `busy` is high in DONE and low in IDLE.
- `start` is ignored in every state except IDLE. It is level-sampled; if held high, a new dump begins on the first IDLE cycle after DONE.
- x00 always reads 0; it is dumped as four 8'h00 bytes.
- Register file writes during a dump are allowed. Each register is snapshotted in its own LOAD cycle; the dump is not atomic across registers. A write landing in the same edge as LOAD is not visible, because `rd_data` reflects the pre-write value.
- Stream length is 1 + 4·N_REGS bytes.

## Timing
- Reset values: `busy`=0, `done`=0, `tx_valid`=0, `tx_data`=8'h00, `rd_addr`=0; state IDLE, snapshot 0, idx 0.
- `rst` low on any edge forces reset values at that edge, mid-stream included. `tx_valid` may drop without a handshake; downstream must tolerate this.
- `start` sampled at edge k → `tx_valid`=1 with HEADER from cycle k+1.
- Valid/ready rule: once `tx_valid` is high, `tx_valid` and `tx_data` stay constant until the handshake cycle. `tx_valid` does not depend combinationally on `tx_ready`.
- `rd_addr` is registered and stable for the whole LOAD and SEND of a register. The snapshot uses `rd_data` at the end of LOAD, so the register file read path has one full cycle.
- With `tx_ready` held high, total cycles from the `start` edge to the `done` cycle inclusive = 1 (HDR) + 5·N_REGS + 1 (DONE). For N_REGS=32 that is 162 cycles.
- Each register costs one bubble cycle (LOAD) with `tx_valid`=0.

## Test plan
- Reset: hold `rst`=0 with `start`=1 for 3 cycles. All outputs stay at reset values and no `tx_valid` appears; after release, `tx_valid` rises 1 cycle after the first sampled `start`.
- Full dump: preload x01=32'hDEADBEEF, x31=32'h12345678, all others 0, `tx_ready`=1, pulse `start`.
  - Byte stream: A5, 00 00 00 00, EF BE AD DE, … , 78 56 34 12 (129 bytes).
  - `done` pulses exactly 162 cycles after the `start` edge; `busy` falls the next cycle.
- Backpressure: same preload with pseudo-random `tx_ready` at ~30%. The byte sequence is identical, and `tx_data`/`tx_valid` never change while `tx_valid`&!`tx_ready`.
- Ignored start and concurrent write:
  - Pulse `start` during SEND of x10: no restart, stream unchanged.
  - Write x20=32'hCAFEF00D while x10 is in SEND: the x20 bytes read 0D F0 FE CA.
- Reset mid-stream: assert `rst` during idx=2 of x05. Next cycle `tx_valid`=0, `busy`=0, `rd_addr`=0. A new `start` restarts from HEADER and x00.
- Parameter check with N_REGS=4, HEADER=8'h5A: exactly 17 bytes (5A then x00..x03). `done` pulses 22 cycles after `start` with `tx_ready`=1.
